// File: rtl/branch_resolver_pkg.sv
// Shared core definitions: branch opcode, predictor geometry defaults and
// the in-flight branch record shared by the resolver and the predictor.
package branch_resolver_pkg;

  // opcode[6:2] pattern of a conditional branch
  localparam logic [4:0] BRANCH_OPCODE = 5'b11000;

  // Predictor geometry defaults
  localparam int INDEX_W_DEFAULT = 10;
  localparam int DEPTH_DEFAULT   = 4;

  // One predicted branch waiting for resolution
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } branch_entry_t;

  localparam int ENTRY_W = $bits(branch_entry_t);

  // True when a 7-bit opcode is a conditional branch
  function automatic logic is_cond_branch(input logic [6:0] opcode);
    return (opcode[6:2] == BRANCH_OPCODE);
  endfunction

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch / execute / predictor-feedback bundle around the branch resolver.
// master = the pipeline side driving fetch and execute, slave = the resolver.
interface branch_resolver_if
  import branch_resolver_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEFAULT
) ();

  // fetch side
  logic               fetch_push;
  logic [31:0]        fetch_pc;
  logic               fetch_pred_taken;
  logic [31:0]        fetch_pred_pc;
  logic               fetch_stall;
  // execute side
  logic               exu_valid;
  logic               exu_taken;
  logic [31:0]        exu_target;
  // predictor feedback and redirect
  logic               feedback_enable;
  logic               taken_branch;
  logic [INDEX_W-1:0] pc_indx_branch;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [15:0]        mispredict_count;
  logic               orphan_err;

  modport master (
    output fetch_push, fetch_pc, fetch_pred_taken, fetch_pred_pc,
    output exu_valid, exu_taken, exu_target,
    input  fetch_stall, feedback_enable, taken_branch, pc_indx_branch,
    input  redirect, redirect_pc, mispredict_count, orphan_err
  );

  modport slave (
    input  fetch_push, fetch_pc, fetch_pred_taken, fetch_pred_pc,
    input  exu_valid, exu_taken, exu_target,
    output fetch_stall, feedback_enable, taken_branch, pc_indx_branch,
    output redirect, redirect_pc, mispredict_count, orphan_err
  );

endinterface

// File: rtl/branch_fifo.sv
// In-order FIFO of in-flight branch records. Push is accepted when there is
// room or when a pop frees a slot in the same cycle; flush empties it and
// takes priority over push and pop.
module branch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;

  logic             push_ok_s;
  logic             pop_ok_s;
  logic [CNT_W-1:0] count_next_s;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;

  // Pointer increment that wraps at DEPTH-1, also for non power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] result;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      result = {PTR_W{1'b0}};
    end else begin
      result = ptr + PTR_W'(1);
    end
    return result;
  endfunction

  // Accept/advance decisions and next occupancy
  always_comb begin
    push_ok_s     = push && ((count_r < CNT_W'(DEPTH)) || pop);
    pop_ok_s      = pop && (count_r != {CNT_W{1'b0}});
    count_next_s  = count_r;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (flush) begin
      count_next_s  = {CNT_W{1'b0}};
      wr_ptr_next_s = {PTR_W{1'b0}};
      rd_ptr_next_s = {PTR_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_next_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_next_s = count_r + CNT_W'(1);
        2'b01:   count_next_s = count_r - CNT_W'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Pointer, occupancy and full-flag registers
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      full_r   <= (count_next_s == CNT_W'(DEPTH));
    end
  end

  // Entry storage; wrong-path pushes during a flush are not written
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_r;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues predicted conditional branches from fetch, compares
// each against its execute-stage outcome in order, produces a one-cycle
// predictor update, and redirects fetch (flushing younger branches) on a
// mispredict.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int INDEX_W = INDEX_W_DEFAULT
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               fetch_push_in,
  input  logic [31:0]        fetch_pc_in,
  input  logic               fetch_pred_taken_in,
  input  logic [31:0]        fetch_pred_pc_in,
  output logic               fetch_stall_out,
  input  logic               exu_valid_in,
  input  logic               exu_taken_in,
  input  logic [31:0]        exu_target_in,
  output logic               feedback_enable_out,
  output logic               taken_branch_out,
  output logic [INDEX_W-1:0] pc_indx_branch_out,
  output logic               redirect_out,
  output logic [31:0]        redirect_pc_out,
  output logic [15:0]        mispredict_count_out,
  output logic               orphan_err_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  branch_entry_t      push_entry_s;
  branch_entry_t      head_s;
  logic [ENTRY_W-1:0] rd_data_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_full_s;

  logic               resolve_s;
  logic               orphan_s;
  logic               mispredict_s;
  logic [31:0]        correct_pc_s;

  logic               feedback_r;
  logic               taken_r;
  logic [INDEX_W-1:0] indx_r;
  logic               redirect_r;
  logic [31:0]        redirect_pc_r;
  logic [15:0]        mispredict_count_r;
  logic               orphan_r;

  branch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .push     (fetch_push_in),
    .pop      (resolve_s),
    .flush    (mispredict_s),
    .wr_data  (push_entry_s),
    .rd_data  (rd_data_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s)
  );

  // Compare the oldest in-flight branch against the execute outcome
  always_comb begin
    push_entry_s            = '{pc: 32'd0, pred_taken: 1'b0, pred_pc: 32'd0};
    push_entry_s.pc         = fetch_pc_in;
    push_entry_s.pred_taken = fetch_pred_taken_in;
    push_entry_s.pred_pc    = fetch_pred_pc_in;
    head_s                  = branch_entry_t'(rd_data_s);
    resolve_s               = exu_valid_in && (fifo_count_s != {CNT_W{1'b0}});
    orphan_s                = exu_valid_in && (fifo_count_s == {CNT_W{1'b0}});
    if (exu_taken_in) begin
      correct_pc_s = exu_target_in;
    end else begin
      correct_pc_s = head_s.pc + 32'd4;
    end
    mispredict_s = 1'b0;
    if (!resolve_s) begin
      mispredict_s = 1'b0;
    end else if (head_s.pred_taken != exu_taken_in) begin
      mispredict_s = 1'b1;
    end else if (exu_taken_in && (head_s.pred_pc != exu_target_in)) begin
      mispredict_s = 1'b1;
    end else begin
      mispredict_s = 1'b0;
    end
  end

  // Registered predictor update, redirect, statistics and error flag
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      feedback_r         <= 1'b0;
      taken_r            <= 1'b0;
      indx_r             <= {INDEX_W{1'b0}};
      redirect_r         <= 1'b0;
      redirect_pc_r      <= 32'd0;
      mispredict_count_r <= 16'd0;
      orphan_r           <= 1'b0;
    end else begin
      feedback_r    <= resolve_s;
      taken_r       <= resolve_s && exu_taken_in;
      indx_r        <= resolve_s ? head_s.pc[INDEX_W-1:0] : {INDEX_W{1'b0}};
      redirect_r    <= mispredict_s;
      redirect_pc_r <= mispredict_s ? correct_pc_s : 32'd0;
      if (mispredict_s) begin
        mispredict_count_r <= sat_inc16(mispredict_count_r);
      end
      orphan_r <= orphan_r || orphan_s;
    end
  end

  assign fetch_stall_out      = fifo_full_s;
  assign feedback_enable_out  = feedback_r;
  assign taken_branch_out     = taken_r;
  assign pc_indx_branch_out   = indx_r;
  assign redirect_out         = redirect_r;
  assign redirect_pc_out      = redirect_pc_r;
  assign mispredict_count_out = mispredict_count_r;
  assign orphan_err_out       = orphan_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, a counter
// saturation sequence, then randomized traffic against a queue-based model.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int DEPTH   = 4;
  localparam int INDEX_W = 10;

  logic clock_in;
  logic reset_in;

  branch_resolver_if #(.INDEX_W(INDEX_W)) bus ();

  branch_resolver #(.DEPTH(DEPTH), .INDEX_W(INDEX_W)) dut (
    .clock_in             (clock_in),
    .reset_in             (reset_in),
    .fetch_push_in        (bus.fetch_push),
    .fetch_pc_in          (bus.fetch_pc),
    .fetch_pred_taken_in  (bus.fetch_pred_taken),
    .fetch_pred_pc_in     (bus.fetch_pred_pc),
    .fetch_stall_out      (bus.fetch_stall),
    .exu_valid_in         (bus.exu_valid),
    .exu_taken_in         (bus.exu_taken),
    .exu_target_in        (bus.exu_target),
    .feedback_enable_out  (bus.feedback_enable),
    .taken_branch_out     (bus.taken_branch),
    .pc_indx_branch_out   (bus.pc_indx_branch),
    .redirect_out         (bus.redirect),
    .redirect_pc_out      (bus.redirect_pc),
    .mispredict_count_out (bus.mispredict_count),
    .orphan_err_out       (bus.orphan_err)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  typedef struct {
    logic rst; logic push; logic [31:0] pc; logic pt; logic [31:0] ppc;
    logic v; logic tk; logic [31:0] tgt;
    logic e_fb; logic e_tk; logic [31:0] e_idx; logic e_rd; logic [31:0] e_rpc;
    logic e_stall; logic e_orph; int e_cnt; int e_mc;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  // reference model state
  branch_entry_t mq[$];
  logic m_fb, m_tk, m_rd, m_orph;
  logic [31:0] m_idx, m_rpc;
  int m_mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic fb, input logic tk,
                           input logic [31:0] idx, input logic rd, input logic [31:0] rpc,
                           input logic stall, input logic orph, input int cnt, input int mc);
    check({tag, " feedback"}, {31'd0, bus.feedback_enable}, {31'd0, fb});
    check({tag, " taken"}, {31'd0, bus.taken_branch}, {31'd0, tk});
    check({tag, " index"}, {22'd0, bus.pc_indx_branch}, idx);
    check({tag, " redirect"}, {31'd0, bus.redirect}, {31'd0, rd});
    check({tag, " redirect_pc"}, bus.redirect_pc, rpc);
    check({tag, " stall"}, {31'd0, bus.fetch_stall}, {31'd0, stall});
    check({tag, " orphan"}, {31'd0, bus.orphan_err}, {31'd0, orph});
    check({tag, " count"}, 32'(dut.u_fifo.count_r), 32'(cnt));
    check({tag, " mcount"}, {16'd0, bus.mispredict_count}, 32'(mc));
  endtask

  task automatic drive(input logic rst, input logic push, input logic [31:0] pc,
                       input logic pt, input logic [31:0] ppc,
                       input logic v, input logic tk, input logic [31:0] tgt);
    reset_in             = rst;
    bus.fetch_push       = push;
    bus.fetch_pc         = pc;
    bus.fetch_pred_taken = pt;
    bus.fetch_pred_pc    = ppc;
    bus.exu_valid        = v;
    bus.exu_taken        = tk;
    bus.exu_target       = tgt;
  endtask

  task automatic add(input logic rst, input logic push, input logic [31:0] pc,
                     input logic pt, input logic [31:0] ppc,
                     input logic v, input logic tk, input logic [31:0] tgt,
                     input logic fb, input logic etk, input logic [31:0] idx,
                     input logic rd, input logic [31:0] rpc, input logic st,
                     input logic orph, input int cnt, input int mc);
    vec_t x;
    x = '{rst, push, pc, pt, ppc, v, tk, tgt, fb, etk, idx, rd, rpc, st, orph, cnt, mc};
    vecs.push_back(x);
  endtask

  // Model of one clock edge from the currently driven inputs
  task automatic model_edge();
    logic resolve, misp;
    logic [31:0] pred_next, act_next;
    int pre_size;
    pre_size = mq.size();
    if (!reset_in) begin
      mq.delete();
      m_fb = 0; m_tk = 0; m_idx = 0; m_rd = 0; m_rpc = 0; m_mc = 0; m_orph = 0;
    end else begin
      resolve = bus.exu_valid && (pre_size > 0);
      misp = 0;
      m_fb = resolve; m_tk = resolve && bus.exu_taken;
      m_idx = 0; m_rd = 0; m_rpc = 0;
      if (resolve) begin
        m_idx     = mq[0].pc % (32'd1 << INDEX_W);
        pred_next = mq[0].pred_taken ? mq[0].pred_pc : mq[0].pc + 32'd4;
        act_next  = bus.exu_taken ? bus.exu_target : mq[0].pc + 32'd4;
        misp      = (mq[0].pred_taken != bus.exu_taken) || (pred_next != act_next);
      end
      if (misp) begin
        mq.delete();
        m_rd = 1; m_rpc = act_next;
        if (m_mc < 65535) m_mc++;
      end else begin
        if (resolve) void'(mq.pop_front());
        if (bus.fetch_push && mq.size() < DEPTH)
          mq.push_back('{pc: bus.fetch_pc, pred_taken: bus.fetch_pred_taken,
                         pred_pc: bus.fetch_pred_pc});
      end
      if (bus.exu_valid && pre_size == 0) m_orph = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    logic [31:0] tgt_pool [4];
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // rst push pc pt ppc v tk tgt | fb tk idx rd rpc stall orph cnt mc
    add(0,1,32'h100,0,0, 1,1,32'h50,  0,0,0,0,0,0,0,0,0);
    add(1,1,32'h100,0,0, 0,0,0,       0,0,0,0,0,0,0,1,0);
    add(1,0,0,0,0,       1,0,0,       1,0,32'h100,0,0,0,0,0,0);
    add(1,1,32'h204,0,0, 0,0,0,       0,0,0,0,0,0,0,1,0);
    add(1,0,0,0,0,       1,1,32'h1F0, 1,1,32'h204,1,32'h1F0,0,0,0,1);
    add(1,1,32'h300,1,32'h340, 0,0,0, 0,0,0,0,0,0,0,1,1);
    add(1,0,0,0,0,       1,0,0,       1,0,32'h300,1,32'h304,0,0,0,2);
    add(1,1,32'h120,0,0, 0,0,0,       0,0,0,0,0,0,0,1,2);
    add(1,1,32'h124,0,0, 0,0,0,       0,0,0,0,0,0,0,2,2);
    add(1,1,32'h128,0,0, 0,0,0,       0,0,0,0,0,0,0,3,2);
    add(1,1,32'h12C,0,0, 0,0,0,       0,0,0,0,0,1,0,4,2);
    add(1,1,32'h130,0,0, 0,0,0,       0,0,0,0,0,1,0,4,2);
    add(1,1,32'h134,0,0, 1,0,0,       1,0,32'h120,0,0,1,0,4,2);
    add(1,0,0,0,0,       1,0,0,       1,0,32'h124,0,0,0,0,3,2);
    add(1,0,0,0,0,       1,0,0,       1,0,32'h128,0,0,0,0,2,2);
    add(1,0,0,0,0,       1,0,0,       1,0,32'h12C,0,0,0,0,1,2);
    add(1,0,0,0,0,       1,0,0,       1,0,32'h134,0,0,0,0,0,2);
    add(1,1,32'h500,0,0, 0,0,0,       0,0,0,0,0,0,0,1,2);
    add(1,1,32'h504,0,0, 0,0,0,       0,0,0,0,0,0,0,2,2);
    add(1,1,32'h508,0,0, 0,0,0,       0,0,0,0,0,0,0,3,2);
    add(1,1,32'h50C,0,0, 1,1,32'h600, 1,1,32'h100,1,32'h600,0,0,0,3);
    add(1,0,0,0,0,       1,0,0,       0,0,0,0,0,0,1,0,3);
    add(1,0,0,0,0,       0,0,0,       0,0,0,0,0,0,1,0,3);
    add(1,1,32'h700,0,0, 0,0,0,       0,0,0,0,0,0,1,1,3);
    add(1,1,32'h704,0,0, 0,0,0,       0,0,0,0,0,0,1,2,3);
    add(0,1,32'h708,0,0, 1,1,32'h10,  0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,       0,0,0,       0,0,0,0,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pc, vecs[i].pt, vecs[i].ppc,
            vecs[i].v, vecs[i].tk, vecs[i].tgt);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_fb, vecs[i].e_tk, vecs[i].e_idx,
                vecs[i].e_rd, vecs[i].e_rpc, vecs[i].e_stall, vecs[i].e_orph,
                vecs[i].e_cnt, vecs[i].e_mc);
    end

    // Mispredict counter saturation from a preloaded value
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    force dut.mispredict_count_r = 16'hFFFE;
    #1;
    release dut.mispredict_count_r;
    tick();
    check("sat preload", {16'd0, bus.mispredict_count}, 32'h0000FFFE);
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 32'h800, 1, 32'h900, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 1, 0, 0);
      tick();
      check($sformatf("sat redirect%0d", k), {31'd0, bus.redirect}, 32'd1);
      check($sformatf("sat rpc%0d", k), bus.redirect_pc, 32'h804);
      check($sformatf("sat count%0d", k), {16'd0, bus.mispredict_count}, 32'h0000FFFF);
    end

    // Randomized traffic against the reference model
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_edge();
    tick();
    tgt_pool[0] = 32'h40; tgt_pool[1] = 32'h80; tgt_pool[2] = 32'hFFFF_FFF0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] pc;
      logic pt;
      pc = $urandom;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      tgt_pool[3] = $urandom;
      pt = $urandom_range(0, 1);
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 6), pc, pt,
            pt ? tgt_pool[$urandom_range(0, 2)] : 32'd0,
            ($urandom_range(0, 9) < 4), $urandom_range(0, 1),
            tgt_pool[$urandom_range(0, 3)]);
      model_edge();
      tick();
      check_all($sformatf("rnd%0d", c), m_fb, m_tk, m_idx, m_rd, m_rpc,
                (mq.size() == DEPTH), m_orph, mq.size(), m_mc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
